// File: rtl/watch_fnd_scanner.sv
// HH.MM scanner for a 4-digit common-anode 7-segment display.
// Binary hour/min are snapshotted once per frame and converted to BCD by a sequential double-dabble.
module watch_fnd_scanner #(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLINK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] hour,
  input  logic [7:0] min,
  input  logic       set_mode,
  output logic [3:0] com_n,
  output logic [7:0] seg_n
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} conv_state_t;

  logic [SCAN_W-1:0]  scan_cnt_reg;
  logic [1:0]         digit_reg;
  logic [BLINK_W-1:0] blink_cnt_reg;
  logic               blink_ph_reg;
  conv_state_t        state_reg, state_next;
  logic [2:0]         shift_cnt_reg;
  logic               first_reg;
  logic [1:0][19:0]   dd_reg;
  logic [1:0][19:0]   dd_step;
  logic [1:0][7:0]    snap_val;
  logic [1:0]         snap_err;
  logic [1:0]         err_conv_reg;
  logic [1:0]         err_disp_reg;
  logic [15:0]        bcd_disp_reg;
  logic               valid_reg;
  logic [3:0]         com_n_reg, com_n_next;
  logic [7:0]         seg_n_reg, seg_n_next;

  logic scan_wrap;
  logic start;

  assign scan_wrap = (scan_cnt_reg == SCAN_MAX);
  // A conversion begins at every frame start (digit 3->0) and right after reset.
  assign start     = first_reg || (scan_wrap && digit_reg == 2'd3);
  assign snap_val  = {hour, min};

  // One double-dabble step: add 3 to any BCD nibble >= 5, then shift left.
  function automatic logic [19:0] dabble(input logic [19:0] v);
    logic [19:0] t;
    t = v;
    for (int k = 0; k < 3; k++) begin
      if (t[8 + 4*k +: 4] >= 4'd5) t[8 + 4*k +: 4] = t[8 + 4*k +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Index 1 is the hour pair, index 0 the minute pair.
  for (genvar gi = 0; gi < 2; gi++) begin : g_pair
    assign dd_step[gi]  = dabble(dd_reg[gi]);
    assign snap_err[gi] = (snap_val[gi] > 8'd99);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  state_next = ST_IDLE;
      ST_SHIFT: if (shift_cnt_reg == 3'd7) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (start) state_next = ST_SHIFT;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      shift_cnt_reg <= '0;
      first_reg     <= 1'b1;
      dd_reg        <= '0;
      err_conv_reg  <= '0;
      err_disp_reg  <= '0;
      bcd_disp_reg  <= '0;
      valid_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      first_reg <= 1'b0;
      if (start) begin
        dd_reg[1]     <= {12'd0, hour};
        dd_reg[0]     <= {12'd0, min};
        err_conv_reg  <= snap_err;
        shift_cnt_reg <= '0;
      end else if (state_reg == ST_SHIFT) begin
        dd_reg        <= dd_step;
        shift_cnt_reg <= shift_cnt_reg + 3'd1;
      end else if (state_reg == ST_DONE) begin
        bcd_disp_reg <= {dd_reg[1][15:8], dd_reg[0][15:8]};
        err_disp_reg <= err_conv_reg;
        valid_reg    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scan_cnt_reg  <= '0;
      digit_reg     <= '0;
      blink_cnt_reg <= '0;
      blink_ph_reg  <= 1'b0;
    end else begin
      if (scan_wrap) begin
        scan_cnt_reg <= '0;
        digit_reg    <= digit_reg + 2'd1;
      end else begin
        scan_cnt_reg <= scan_cnt_reg + SCAN_W'(1);
      end
      if (blink_cnt_reg == BLINK_MAX) begin
        blink_cnt_reg <= '0;
        blink_ph_reg  <= ~blink_ph_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
      end
    end
  end

  always_comb begin
    logic [3:0] nib;
    logic [6:0] glyph;
    logic       dp_on;
    nib        = bcd_disp_reg[{digit_reg, 2'b00} +: 4];
    glyph      = err_disp_reg[digit_reg[1]] ? 7'h3F : seg7(nib);
    dp_on      = (digit_reg == 2'd2) && (set_mode || !blink_ph_reg);
    com_n_next = 4'hF;
    seg_n_next = 8'hFF;
    if (valid_reg) begin
      com_n_next = ~(4'b0001 << digit_reg);
      if (!(set_mode && blink_ph_reg)) seg_n_next = {~dp_on, glyph};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      com_n_reg <= 4'hF;
      seg_n_reg <= 8'hFF;
    end else begin
      com_n_reg <= com_n_next;
      seg_n_reg <= seg_n_next;
    end
  end

  assign com_n = com_n_reg;
  assign seg_n = seg_n_reg;

endmodule

// File: tb/tb_watch_fnd_scanner.sv
// Bench for watch_fnd_scanner: directed phases plus random inputs, every cycle compared
// against a frame-level model built from edge counts since reset.
module tb_watch_fnd_scanner;
  localparam int SD = 16;
  localparam int BD = 256;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] hour = 8'd0;
  logic [7:0] min = 8'd0;
  logic       set_mode = 1'b0;
  logic [3:0] com_n;
  logic [7:0] seg_n;

  watch_fnd_scanner #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .reset_n(reset_n), .hour(hour), .min(min),
    .set_mode(set_mode), .com_n(com_n), .seg_n(seg_n)
  );

  always #5 clk = ~clk;

  typedef struct { int ready; int h; int m; } conv_t;

  int    tests = 0;
  int    fails = 0;
  int    n = 0;
  int    disp_h = 0;
  int    disp_m = 0;
  bit    valid_m = 1'b0;
  conv_t pend[$];
  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Expected outputs produced by edge n, i.e. from model state after edge m = n-1.
  task automatic expect_out(input int m, input bit sm, output logic [3:0] ec, output logic [7:0] es);
    int d, v;
    bit ph;
    ec = 4'hF;
    es = 8'hFF;
    if (valid_m) begin
      d  = (m / SD) % 4;
      ph = ((m / BD) % 2) == 1;
      ec = 4'hF ^ (4'b0001 << d);
      if (!(sm && ph)) begin
        v = (d >= 2) ? disp_h : disp_m;
        if (v > 99) es = 8'hBF;
        else        es = seg_tab[(d % 2 == 0) ? (v % 10) : (v / 10)];
        if (d == 2 && (sm || !ph)) es[7] = 1'b0;
      end
    end
  endtask

  task automatic tick(input string tag);
    logic [3:0] ec;
    logic [7:0] es;
    bit   rst, sm;
    int   h_in, m_in;
    conv_t c;
    rst  = !reset_n;
    sm   = set_mode;
    h_in = int'(hour);
    m_in = int'(min);
    @(posedge clk);
    if (rst) begin
      ec = 4'hF; es = 8'hFF;
      n = 0; valid_m = 1'b0; disp_h = 0; disp_m = 0;
      pend.delete();
    end else begin
      n++;
      expect_out(n - 1, sm, ec, es);
      if (n == 1 || n % (4 * SD) == 0) begin
        c.ready = n + 9; c.h = h_in; c.m = m_in;
        pend.push_back(c);
      end
      if (pend.size() > 0 && pend[0].ready == n) begin
        disp_h = pend[0].h;
        disp_m = pend[0].m;
        valid_m = 1'b1;
        void'(pend.pop_front());
      end
    end
    #1;
    tests++;
    assert (com_n === ec) else begin
      fails++;
      $error("FAIL %s com_n: observed %h expected %h (edge %0d)", tag, com_n, ec, n);
    end
    tests++;
    assert (seg_n === es) else begin
      fails++;
      $error("FAIL %s seg_n: observed %h expected %h (edge %0d)", tag, seg_n, es, n);
    end
  endtask

  task automatic run(input int k, input string tag);
    for (int i = 0; i < k; i++) tick(tag);
  endtask

  // Advance until the edge count sits at phase p within a frame; bounded by one frame.
  task automatic wait_phase(input int p, input string tag);
    int guard;
    guard = 0;
    while (n % (4 * SD) != p && guard < 4 * SD + 2) begin
      tick(tag);
      guard++;
    end
    tests++;
    assert (n % (4 * SD) == p) else begin
      fails++;
      $error("FAIL %s phase wait: observed %0d expected %0d", tag, n % (4 * SD), p);
    end
  endtask

  initial begin
    reset_n = 1'b0; hour = 8'd12; min = 8'd34; set_mode = 1'b0;
    run(5, "reset");
    reset_n = 1'b1;
    run(10, "first_conv");
    tests++;
    assert (com_n === 4'hF) else begin
      fails++; $error("FAIL pre_valid com_n: observed %h expected %h", com_n, 4'hF);
    end
    tick("first_digit");
    tests++;
    assert (com_n === 4'hE && seg_n === 8'h99) else begin
      fails++; $error("FAIL first_digit: observed %h/%h expected E/99", com_n, seg_n);
    end
    run(120, "scan_1234");

    wait_phase(SD + 3, "to_digit1");
    min = 8'd35;
    run(200, "min_35");

    hour = 8'd23; min = 8'd59;
    run(130, "23_59");
    hour = 8'd0; min = 8'd0;
    run(130, "rollover");

    set_mode = 1'b1;
    run(600, "set_mode");
    set_mode = 1'b0;

    hour = 8'd100; min = 8'd7;
    run(130, "err_pair");

    hour = 8'd9; min = 8'd41;
    wait_phase(4, "to_shift4");
    reset_n = 1'b0;
    tick("mid_conv_rst");
    tests++;
    assert (com_n === 4'hF && seg_n === 8'hFF) else begin
      fails++; $error("FAIL mid_conv_rst: observed %h/%h expected F/FF", com_n, seg_n);
    end
    reset_n = 1'b1;
    run(100, "after_rst");

    for (int i = 0; i < 25; i++) begin
      hour = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(100, 255)) : 8'($urandom_range(0, 23));
      min  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(100, 255)) : 8'($urandom_range(0, 59));
      set_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) begin
        reset_n = 1'b0;
        run(int'($urandom_range(1, 3)), "rand_rst");
        reset_n = 1'b1;
      end
      run(int'($urandom_range(5, 150)), "random");
    end

    set_mode = 1'b0;
    for (int i = 0; i < 200; i++) begin
      hour = 8'($urandom_range(0, 23));
      min  = 8'($urandom_range(0, 59));
      tick("churn");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
